pwm_led_ctrl: RTL and testbench

Memory-mapped LED peripheral directly downstream of the processor core: it consumes the core's data-memory store/load port for a small register window and drives the board's RGB_R, RGB_G, RGB_B and LED pins with per-channel PWM. It replaces direct bit-banging of the LED pins. Duty changes are glitch-free because new duty values are applied only at PWM period boundaries.

---
 rtl/pwm_led_pkg.sv | 28 ++
 rtl/pwm_channel.sv | 56 +++++
 rtl/pwm_led_ctrl.sv | 129 ++++++++++++
 tb/tb_pwm_led_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_led_pkg.sv
// Shared constants for the PWM LED peripheral: register addresses, channel indices, default width.
// The optional fade feature is selected with the PWM_LED_FADE_EN macro.
package pwm_led_pkg;

  localparam int PWM_BITS_DEFAULT = 8;
  localparam int NUM_CH           = 4;

  localparam logic [3:0] ADDR_DUTY_R    = 4'd0;
  localparam logic [3:0] ADDR_DUTY_G    = 4'd1;
  localparam logic [3:0] ADDR_DUTY_B    = 4'd2;
  localparam logic [3:0] ADDR_DUTY_L    = 4'd3;
  localparam logic [3:0] ADDR_CTRL      = 4'd4;
  localparam logic [3:0] ADDR_PERIODS   = 4'd5;
  localparam logic [3:0] ADDR_FADE_STEP = 4'd6;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2,
    CH_L = 2'd3
  } ch_e;

  // DUTY registers sit contiguously from ADDR_DUTY_R in channel order.
  function automatic logic [3:0] duty_addr(input ch_e ch);
    return ADDR_DUTY_R + {2'b00, ch};
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: CPU-visible pending duty, period-aligned active duty and registered comparator.
// With PWM_LED_FADE_EN defined the active duty ramps toward the pending target by fade_step per period.
module pwm_channel
  import pwm_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [PWM_BITS-1:0] wr_duty,
`ifdef PWM_LED_FADE_EN
  input  logic [PWM_BITS-1:0] fade_step,
`endif
  output logic [PWM_BITS-1:0] pending,
  output logic                on
);

  logic [PWM_BITS-1:0] active;
  logic [PWM_BITS-1:0] next_active;
`ifdef PWM_LED_FADE_EN
  logic [PWM_BITS-1:0] gap;
`endif

  always_comb begin
    next_active = pending;
`ifdef PWM_LED_FADE_EN
    gap = (pending > active) ? pending - active : active - pending;
    // A step of zero, or a remaining gap within one step, lands on the target.
    if (fade_step != '0 && gap > fade_step) begin
      next_active = (pending > active) ? active + fade_step : active - fade_step;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      active  <= '0;
      on      <= 1'b0;
    end else begin
      if (wr_en) begin
        pending <= wr_duty;
      end
      if (tick && boundary) begin
        active <= next_active;
      end
      on <= enable && (pwm_cnt < active);
    end
  end

endmodule

// File: rtl/pwm_led_ctrl.sv
// Memory-mapped RGB + user LED PWM peripheral: prescaler, PWM counter, CTRL/PERIODS registers, read mux.
// Fade ramping (and the FADE_STEP register) is compiled in only when PWM_LED_FADE_EN is defined.
module pwm_led_ctrl
  import pwm_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT,
  parameter int PRESCALE = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B,
  output logic        LED
);

  localparam int             PSW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);

  logic [PSW-1:0]      presc_cnt;
  logic                tick;
  logic                boundary;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [4:0]          ctrl;
  logic [15:0]         periods;
  logic [PWM_BITS-1:0] pending [NUM_CH];
  logic [NUM_CH-1:0]   ch_on;
  logic [31:0]         rd_mux;
  logic                unused_wdata;
`ifdef PWM_LED_FADE_EN
  logic [PWM_BITS-1:0] fade_step;
`endif

  // Only the low bits of the store data reach any register.
  assign unused_wdata = ^wdata;

  assign tick     = (presc_cnt == PRESC_LAST);
  assign boundary = tick && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      periods   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PSW'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      if (boundary) begin
        periods <= periods + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (we && addr == ADDR_CTRL) begin
      ctrl <= wdata[4:0];
    end
  end

`ifdef PWM_LED_FADE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fade_step <= '0;
    end else if (we && addr == ADDR_FADE_STEP) begin
      fade_step <= wdata[PWM_BITS-1:0];
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .boundary  (boundary),
      .pwm_cnt   (pwm_cnt),
      .enable    (ctrl[0] && ctrl[i+1]),
      .wr_en     (we && addr == duty_addr(ch_e'(i))),
      .wr_duty   (wdata[PWM_BITS-1:0]),
`ifdef PWM_LED_FADE_EN
      .fade_step (fade_step),
`endif
      .pending   (pending[i]),
      .on        (ch_on[i])
    );
  end

  // Mux reads current register contents, so a same-cycle write is seen on the next read.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DUTY_R:    rd_mux = 32'(pending[CH_R]);
      ADDR_DUTY_G:    rd_mux = 32'(pending[CH_G]);
      ADDR_DUTY_B:    rd_mux = 32'(pending[CH_B]);
      ADDR_DUTY_L:    rd_mux = 32'(pending[CH_L]);
      ADDR_CTRL:      rd_mux = 32'(ctrl);
      ADDR_PERIODS:   rd_mux = 32'(periods);
`ifdef PWM_LED_FADE_EN
      ADDR_FADE_STEP: rd_mux = 32'(fade_step);
`endif
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_mux;
    end
  end

  assign RGB_R = ~ch_on[CH_R];
  assign RGB_G = ~ch_on[CH_G];
  assign RGB_B = ~ch_on[CH_B];
  assign LED   =  ch_on[CH_L];

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Bench for pwm_led_ctrl: time-based reference model, read scoreboard, per-cycle pin checks.
module tb_pwm_led_ctrl;

  localparam int P   = 2;
  localparam int PB  = 8;
  localparam int PER = P * 256;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] rdata;
  logic        RGB_R, RGB_G, RGB_B, LED;

  int tests = 0;
  int fails = 0;

  pwm_led_ctrl #(.PWM_BITS(PB), .PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B),
    .LED   (LED)
  );

  always #5 clk = ~clk;

  // Reference model state: e is the number of clock edges since reset released.
  int          e         = 0;
  logic [4:0]  m_ctrl    = '0;
  logic [15:0] m_periods = '0;
  int          m_pend [4] = '{0, 0, 0, 0};
  int          m_act  [4] = '{0, 0, 0, 0};
  int          m_step    = 0;
  logic [3:0]  exp_on    = '0;
  logic [31:0] m_hold    = '0;
  logic [31:0] rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0, 4'd1, 4'd2, 4'd3: return 32'(m_pend[a[1:0]]);
      4'd4: return {27'd0, m_ctrl};
      4'd5: return {16'd0, m_periods};
`ifdef PWM_LED_FADE_EN
      4'd6: return 32'(m_step);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int fade_next(input int act, input int tgt);
`ifdef PWM_LED_FADE_EN
    if (m_step == 0) return tgt;
    if (tgt >= act) return act + min2(m_step, tgt - act);
    return act - min2(m_step, act - tgt);
`else
    return tgt + 0 * act;
`endif
  endfunction

  // Model: PWM position and period boundaries follow from the edge count alone.
  initial begin
    int       pos;
    logic [3:0] on_now;
    logic [31:0] rv;
    forever begin
      @(posedge clk);
      if (reset) begin
        e = 0;
        m_ctrl = '0;
        m_periods = '0;
        m_step = 0;
        for (int i = 0; i < 4; i++) begin
          m_pend[i] = 0;
          m_act[i]  = 0;
        end
        exp_on = '0;
        m_hold = '0;
      end else begin
        pos = (e / P) % 256;
        for (int i = 0; i < 4; i++)
          on_now[i] = m_ctrl[0] && m_ctrl[i+1] && (pos < m_act[i]);
        if (re) begin
          rv = model_read(addr);
          rd_q.push_back(rv);
          m_hold = rv;
        end
        if (((e + 1) % PER) == 0) begin
          m_periods = m_periods + 16'd1;
          for (int i = 0; i < 4; i++) m_act[i] = fade_next(m_act[i], m_pend[i]);
        end
        if (we) begin
          if (addr < 4'd4) m_pend[addr[1:0]] = int'(wdata[7:0]);
          else if (addr == 4'd4) m_ctrl = wdata[4:0];
`ifdef PWM_LED_FADE_EN
          else if (addr == 4'd6) m_step = int'(wdata[7:0]);
`endif
        end
        exp_on = on_now;
        e++;
      end
    end
  end

  // Monitor: pins every cycle, rdata popped from the scoreboard after each load.
  initial begin
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      check1("RGB_R", RGB_R, ~exp_on[0]);
      check1("RGB_G", RGB_G, ~exp_on[1]);
      check1("RGB_B", RGB_B, ~exp_on[2]);
      check1("LED",   LED,    exp_on[3]);
      if (rd_q.size() > 0) begin
        exp_rd = rd_q.pop_front();
        check("rdata", rdata, exp_rd);
      end else begin
        check("rdata_hold", rdata, m_hold);
      end
    end
  end

  task automatic op(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pin(input int idx, input int n, output int cnt);
    logic [3:0] pins;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      pins = {LED, RGB_B, RGB_G, RGB_R};
      cnt += int'(pins[idx]);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int guard;
    int k;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    op(0, 1, 4'd5, 0);
    op(0, 1, 4'd0, 0);
    idle(520);
    op(0, 1, 4'd5, 0);
    check("periods_after_512", rdata, 32'd1);

    op(1, 0, 4'd4, 32'h1F);
    op(1, 0, 4'd3, 32'd64);
    idle(1100);
    count_pin(3, PER, cnt);
    check("led_high_clks", cnt, 128);

    guard = 0;
    while ((((e + 1) % PER) != 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check1("boundary_found", guard < 1000, 1'b1);
    op(1, 0, 4'd0, 32'd128);
    count_pin(0, PER, cnt);
    check("rgb_r_first_period_high", cnt, PER);
    count_pin(0, PER, cnt);
    check("rgb_r_second_period_high", cnt, PER / 2);

    op(1, 0, 4'd1, 32'd0);
    idle(1100);
    count_pin(1, PER, cnt);
    check("rgb_g_duty0_high", cnt, PER);
    op(1, 0, 4'd1, 32'd255);
    idle(1100);
    count_pin(1, PER, cnt);
    check("rgb_g_duty255_high", cnt, 2);
    op(1, 0, 4'd4, 32'h1B);
    @(negedge clk);
    check1("rgb_g_disabled", RGB_G, 1'b1);

    op(1, 0, 4'd0, 32'd10);
    op(1, 1, 4'd0, 32'd20);
    check("same_cycle_rw_old", rdata, 32'd10);
    op(0, 1, 4'd0, 0);
    check("read_after_write", rdata, 32'd20);
    op(0, 1, 4'd9, 0);
    check("unmapped_read", rdata, 32'd0);

    op(1, 0, 4'd4, 32'h1F);
    idle(300 + $urandom_range(0, 200));
    pulse_reset();
    op(0, 1, 4'd0, 0);
    check("duty_r_after_reset", rdata, 32'd0);

`ifdef PWM_LED_FADE_EN
    op(1, 0, 4'd6, 32'd16);
    op(1, 0, 4'd4, 32'h1F);
    op(1, 0, 4'd2, 32'd40);
    idle(5 * PER);
    op(0, 1, 4'd2, 0);
    check("fade_target_read", rdata, 32'd40);
    op(1, 0, 4'd2, 32'd200);
    idle(PER + 200);
    pulse_reset();
    check1("rgb_b_after_reset", RGB_B, 1'b1);
    op(0, 1, 4'd6, 0);
    check("fade_step_reset", rdata, 32'd0);
`endif

    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 19);
      if (k < 6)       op(1, 0, 4'($urandom_range(0, 7)), $urandom);
      else if (k < 11) op(0, 1, 4'($urandom_range(0, 15)), 0);
      else if (k < 13) op(1, 1, 4'($urandom_range(0, 15)), $urandom);
      else if (k < 14) op(1, 0, 4'd4, 32'($urandom_range(0, 31)));
      else if (k == 19 && $urandom_range(0, 9) == 0) pulse_reset();
      else             idle($urandom_range(1, 40));
    end
    idle(2 * PER);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
